uart_rx_byte: RTL and testbench

//  Serial UART receiver (8N1) that deserialises the board RX pin into bytes.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_byte_if.sv | 14 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_byte.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// baud divider calculation used by the receiver and a future transmitter.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input longint clk, input longint baud, input longint os);
    longint den;
    den = baud * os;
    return int'((clk + den / 64'sd2) / den);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bundle: serial line in, byte / ready / framing error out.
`timescale 1ns/1ps
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      data_ready;
  logic                      framing_error;

  modport master (output rx, input data_out, input data_ready, input framing_error);
  modport slave  (input rx, output data_out, output data_ready, output framing_error);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable
// through clear so the receiver can phase-align it to a start edge.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clock100,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [TW-1:0] r_cnt;

  // Divider counter, cleared at its terminal value so it never wraps.
  always_ff @(posedge clock100) begin
    if (reset || clear) begin
      r_cnt <= {TW{1'b0}};
    end else if (r_cnt == TW'(DIV - 1)) begin
      r_cnt <= {TW{1'b0}};
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign tick = (r_cnt == TW'(DIV - 1));

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rx, frames bytes on oversample ticks and
// presents each good byte with a fixed-length data_ready window.
`timescale 1ns/1ps
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int READY_HOLD = 32
) (
  input  logic     clock100,
  input  logic     reset,
  uart_rx_byte_if.slave bus
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW   = $clog2(OVERSAMPLE) + 1;
  localparam int HW   = $clog2(READY_HOLD + 1);
  localparam int IW   = $clog2(UART_DATA_BITS);
  localparam int HALF = OVERSAMPLE / 2;

  logic                      r_sync1, r_sync2, w_rx_s;
  logic                      w_tick, w_clear, w_good, w_ferr;
  uart_rx_state_t            r_state, w_state_nxt;
  logic [SW-1:0]             r_scnt, w_scnt_nxt;
  logic [IW-1:0]             r_idx, w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [UART_DATA_BITS-1:0] r_data_out;
  logic                      r_ready, r_ferr;
  logic [HW-1:0]             r_hold;

  assign w_rx_s = r_sync2;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clock100 (clock100),
    .reset    (reset),
    .clear    (w_clear),
    .tick     (w_tick)
  );

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock100) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  // Framing FSM next-state and datapath updates.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_clear     = 1'b0;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      WAIT_IDLE: begin
        if (!w_tick) begin
          w_scnt_nxt = r_scnt;
        end else if (!w_rx_s) begin
          w_scnt_nxt = {SW{1'b0}};
        end else if (r_scnt == SW'(OVERSAMPLE - 1)) begin
          w_scnt_nxt  = {SW{1'b0}};
          w_state_nxt = IDLE;
        end else begin
          w_scnt_nxt = r_scnt + SW'(1);
        end
      end
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_scnt_nxt  = {SW{1'b0}};
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (!w_tick) begin
          w_scnt_nxt = r_scnt;
        end else if (r_scnt == SW'(HALF - 1)) begin
          w_scnt_nxt = {SW{1'b0}};
          if (!w_rx_s) begin
            w_state_nxt = DATA;
            w_idx_nxt   = {IW{1'b0}};
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_scnt_nxt = r_scnt + SW'(1);
        end
      end
      DATA: begin
        if (!w_tick) begin
          w_scnt_nxt = r_scnt;
        end else if (r_scnt == SW'(OVERSAMPLE - 1)) begin
          w_scnt_nxt         = {SW{1'b0}};
          w_shift_nxt[r_idx] = w_rx_s;
          if (r_idx == IW'(UART_DATA_BITS - 1)) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end else begin
          w_scnt_nxt = r_scnt + SW'(1);
        end
      end
      STOP: begin
        if (!w_tick) begin
          w_scnt_nxt = r_scnt;
        end else if (r_scnt == SW'(OVERSAMPLE - 1)) begin
          w_scnt_nxt = {SW{1'b0}};
          if (w_rx_s) begin
            w_good      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else begin
          w_scnt_nxt = r_scnt + SW'(1);
        end
      end
      default: begin
        w_state_nxt = WAIT_IDLE;
        w_scnt_nxt  = {SW{1'b0}};
      end
    endcase
  end

  // FSM state and capture registers.
  always_ff @(posedge clock100) begin
    if (reset) begin
      r_state <= WAIT_IDLE;
      r_scnt  <= {SW{1'b0}};
      r_idx   <= {IW{1'b0}};
      r_shift <= {UART_DATA_BITS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Output byte, ready window (reloads on a new byte without a gap) and error pulse.
  always_ff @(posedge clock100) begin
    if (reset) begin
      r_data_out <= {UART_DATA_BITS{1'b0}};
      r_ready    <= 1'b0;
      r_ferr     <= 1'b0;
      r_hold     <= {HW{1'b0}};
    end else begin
      r_ferr <= w_ferr;
      if (w_good) begin
        r_data_out <= r_shift;
        r_hold     <= HW'(READY_HOLD);
        r_ready    <= 1'b1;
      end else if (r_hold != {HW{1'b0}}) begin
        r_hold  <= r_hold - HW'(1);
        r_ready <= (r_hold != HW'(1));
      end else begin
        r_ready <= 1'b0;
      end
    end
  end

  assign bus.data_out      = r_data_out;
  assign bus.data_ready    = r_ready;
  assign bus.framing_error = r_ferr;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: table of frames plus hand-written
// glitch and mid-frame reset sequences, with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  // Line rate raised above 115200 so the whole sequence stays short.
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 460_800;
  localparam int OS       = 16;
  localparam int HOLD     = 32;
  localparam int DIV_TB   = (CLK_FREQ + (BAUD * OS) / 2) / (BAUD * OS);
  localparam int BIT_NS   = DIV_TB * OS * 10;
  localparam int LAT_EXP  = 3 + (DIV_TB * OS * 19) / 2;
  localparam int BIT_FAST = ((BIT_NS * 97) / 1000) * 10;
  localparam int BIT_SLOW = ((BIT_NS * 103) / 1000) * 10;

  logic clock100 = 1'b0;
  logic reset    = 1'b1;
  int   cyc      = 0;

  uart_rx_byte_if bus();

  uart_rx_byte #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .READY_HOLD (HOLD)
  ) dut (
    .clock100 (clock100),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock100 = ~clock100;

  always @(posedge clock100) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         bit_ns;
    bit         stop_ok;
    int         idle_bits;
    bit         chk_lat;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         fe_seen = 0;
  int         fe_exp = 0;
  logic [7:0] last_good = 8'h00;
  bit         lat_armed = 1'b0;
  int         lat_t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int bit_ns, input bit stop_ok);
    bus.rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      #(bit_ns);
    end
    bus.rx = stop_ok;
    #(bit_ns);
    bus.rx = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock100);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.stop_ok) exp_q.push_back(v.data);
    else fe_exp++;
    if (v.chk_lat) begin
      lat_t0    = cyc;
      lat_armed = 1'b1;
    end
    send_frame(v.data, v.bit_ns, v.stop_ok);
    if (v.stop_ok) last_good = v.data;
    #(v.idle_bits * BIT_NS);
    wait_drain(4 * DIV_TB * OS);
    check("data_hold", bus.data_out, last_good);
    check("fe_count", fe_seen, fe_exp);
  endtask

  // Monitor: scoreboard pop on ready rise, ready window length, error pulse width.
  initial begin
    bit prev_rdy = 1'b0;
    bit prev_fe  = 1'b0;
    int rdy_len  = 0;
    forever begin
      @(negedge clock100);
      if (reset) begin
        prev_rdy = 1'b0;
        prev_fe  = 1'b0;
        rdy_len  = 0;
      end else begin
        if (bus.data_ready && !prev_rdy) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_ready: got data_out %0h, expected no byte (t=%0t)", bus.data_out, $time);
          end else begin
            check("data_out", bus.data_out, exp_q.pop_front());
          end
          if (lat_armed) begin
            check("latency_in_window",
                  ((cyc - lat_t0) >= LAT_EXP - 2) && ((cyc - lat_t0) <= LAT_EXP + 4), 1);
            lat_armed = 1'b0;
          end
          rdy_len = 1;
        end else if (bus.data_ready) begin
          rdy_len++;
        end else if (prev_rdy) begin
          check("ready_len", rdy_len, HOLD);
        end
        if (bus.framing_error) begin
          fe_seen++;
          if (prev_fe) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fe_width: framing_error high 2+ cycles, required 1 (t=%0t)", $time);
          end
        end
        prev_rdy = bus.data_ready;
        prev_fe  = bus.framing_error;
      end
    end
  end

  initial begin
    bus.rx = 1'b1;
    vecs[0] = '{8'h41, BIT_NS,   1'b1, 2, 1'b1};
    vecs[1] = '{8'h0D, BIT_NS,   1'b1, 0, 1'b0};
    vecs[2] = '{8'h1B, BIT_NS,   1'b1, 2, 1'b0};
    vecs[3] = '{8'h55, BIT_NS,   1'b1, 2, 1'b0};
    vecs[4] = '{8'hA5, BIT_NS,   1'b0, 2, 1'b0};
    vecs[5] = '{8'h3C, BIT_NS,   1'b1, 2, 1'b0};
    vecs[6] = '{8'h7E, BIT_NS,   1'b1, 2, 1'b0};
    vecs[7] = '{8'h96, BIT_SLOW, 1'b1, 2, 1'b0};
    vecs[8] = '{8'h96, BIT_FAST, 1'b1, 2, 1'b0};

    repeat (4) @(negedge clock100);
    check("rst_data_out", bus.data_out, 0);
    check("rst_data_ready", bus.data_ready, 0);
    check("rst_framing_error", bus.framing_error, 0);
    reset = 1'b0;
    #(2 * BIT_NS);

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Short low glitch must be rejected in START.
    bus.rx = 1'b0;
    #200;
    bus.rx = 1'b1;
    #(2 * BIT_NS);
    check("glitch_data_out", bus.data_out, last_good);
    check("glitch_fe_count", fe_seen, fe_exp);

    for (int i = 3; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of data bit 4 of 0xFF, line continues with the frame tail.
    bus.rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'b1;
      #(BIT_NS);
    end
    #(BIT_NS / 2);
    reset = 1'b1;
    repeat (3) @(negedge clock100);
    check("midrst_data_out", bus.data_out, 0);
    check("midrst_data_ready", bus.data_ready, 0);
    check("midrst_framing_error", bus.framing_error, 0);
    reset = 1'b0;
    last_good = 8'h00;
    #(6 * BIT_NS);
    check("after_tail_data_out", bus.data_out, last_good);

    for (int i = 6; i < 9; i++) run_vec(vecs[i]);

    check("queue_empty", exp_q.size(), 0);
    check("fe_total", fe_seen, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
